gcd_stein_unit: RTL and testbench
=================================

# gcd_stein_unit

Parametrised, handshaked GCD engine that computes the greatest common divisor of two unsigned WIDTH-bit operands with the binary (Stein) algorithm. It replaces the free-running, 8-bit, positive-only subtraction GCD with an engine that has these additions:
- a start/busy/done handshake;
- an asynchronous reset;
- defined zero-operand results;
- a latency bound that is linear in WIDTH.

It sits as a multi-cycle arithmetic unit beside the datapath, driven by a controller that issues one request at a time.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- a  input  WIDTH  operand A, unsigned; sampled on accepted start
- b  input  WIDTH  operand B, unsigned; sampled on accepted start
- busy  output  1  high while in REDUCE
- done  output  1  one-cycle pulse; out valid and updated in the same cycle
- out  output  WIDTH  last result; held until the next completion

## Operation
- Internal registers: x, y (WIDTH each), k (shift count, $clog2(WIDTH+1) bits), state ∈ {IDLE, REDUCE}.
- IDLE, start=1 (accepted start):
  - if a==0 or b==0: out<=a|b, done<=1, stay in IDLE. This gives gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
  - otherwise: x<=a, y<=b, k<=0, go to REDUCE.
- IDLE, start=0: no change; done<=0.
- REDUCE: exactly one rule per clock, evaluated in this priority order:
  1. x even and y even: x<=x>>1, y<=y>>1, k<=k+1
  2. x even: x<=x>>1
  3. y even: y<=y>>1
  4. x==y: out<=x<<k, done<=1, go to IDLE
  5. x>y: x<=(x-y)>>1
  6. otherwise: y<=(y-x)>>1
- Arithmetic rules:
  - all operations are unsigned;
  - the subtraction in rules 5/6 never underflows;
  - x<<k never exceeds min(a,b), so out fits in WIDTH and has no overflow.
- start while busy=1: ignored; operands are not resampled and the computation in progress is unaffected.
- a and b may change freely after the accepted start edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, out=0; x, y, k=0.
- Reset asserted mid-REDUCE: the computation is aborted immediately and all outputs take their reset values. After release, the engine waits for a new start.
- Zero-operand latency: done and out are valid in the cycle after the accepted start edge (1 cycle).
- Nonzero latency: 1 load edge plus R REDUCE edges, where 1 ≤ R ≤ 2·WIDTH+1. done is visible after edge 1+R.
  - Worked cases: gcd(1,1) R=1; gcd(4,2) R=3; gcd(5,3) R=3; gcd(255,3) R=7.
- done is high for exactly one cycle per accepted start; busy is low in that cycle.
- Back-to-back requests: a start asserted in the done cycle is accepted, since state is IDLE. Its own done follows at the normal latency, so a new request can be issued with no idle gap.
- A held start level launches a new computation every time the engine returns to IDLE.

## Test plan
- Reset, then idle: rst pulse with start=0 for 10 cycles -> out=0, done=0, busy=0 throughout.
- Zero operands: (a,b)=(0,0), (0,9), (12,0) -> out=0, 9, 12 respectively; each done exactly 1 cycle after start; busy never rises.
- Latency-checked set at WIDTH=8: (1,1)->1 at R=1; (4,2)->2 at R=3; (5,3)->1 at R=3; (255,3)->3 at R=7; (7,1)->1. Each done pulse is one cycle wide and out holds afterwards.
- Handshake abuse:
  - start (48,18), then pulse start with (9,6) while busy -> single result 6, no second done;
  - start re-asserted in the done cycle with (9,6) -> accepted, next done gives 3.
- Reset mid-operation: start (255,3), assert rst 3 cycles later -> done never pulses; out=0, busy=0. A fresh start (100,75) then gives 25.
- Width sweep: WIDTH=16, (65535,65535)->65535; (40960,1024)->1024; (65521,65519)->1. Every case finishes within 33 REDUCE cycles, and the bench checks against a reference GCD over 1000 random pairs.

Source files
------------

// File: rtl/gcd_stein_unit.sv
// Binary (Stein) GCD engine with a start/busy/done handshake.
// Zero operands finish straight from IDLE; nonzero pairs run one REDUCE rule per clock.
module gcd_stein_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        REDUCE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] x, x_n;
    logic [WIDTH-1:0] y, y_n;
    logic [KW-1:0]    k, k_n;
    logic [WIDTH-1:0] out_n;
    logic             done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            k     <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            k     <= k_n;
            out   <= out_n;
            done  <= done_n;
        end
    end

    // k counts the common factors of two removed; it restores them on completion
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        k_n     = k;
        out_n   = out;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (a == '0 || b == '0) begin
                        out_n  = a | b;
                        done_n = 1'b1;
                    end else begin
                        x_n     = a;
                        y_n     = b;
                        k_n     = '0;
                        state_n = REDUCE;
                    end
                end
            end
            REDUCE: begin
                if (!x[0] && !y[0]) begin
                    x_n = x >> 1;
                    y_n = y >> 1;
                    k_n = k + KW'(1);
                end else if (!x[0]) begin
                    x_n = x >> 1;
                end else if (!y[0]) begin
                    y_n = y >> 1;
                end else if (x == y) begin
                    out_n   = x << k;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (x > y) begin
                    x_n = (x - y) >> 1;
                end else begin
                    y_n = (y - x) >> 1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == REDUCE);

endmodule

// File: tb/tb_gcd_stein_unit.sv
// Self-checking bench: directed handshake/latency cases at WIDTH=8 and a
// randomized sweep at WIDTH=16 against a Euclid-based reference GCD.
module tb_gcd_stein_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8, out8;
    logic [15:0] a16, b16, out16;
    logic        busy8, done8, busy16, done16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_stein_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .out(out8)
    );

    gcd_stein_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .out(out16)
    );

    // Euclid by remainder: deliberately a different algorithm from the DUT
    function automatic logic [15:0] ref_gcd(input logic [15:0] p, input logic [15:0] q);
        logic [15:0] t;
        while (q != 16'd0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit w16, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        if (w16) begin
            a16 = av; b16 = bv; start16 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Called #1 after the accepting edge; r counts further edges until done
    task automatic waitDone(input bit w16, output int r, output logic [15:0] res, output bit busy_bad);
        bit ok;
        r = 0;
        ok = (w16 ? done16 : done8);
        busy_bad = 1'b0;
        while (!ok && r < 40) begin
            if (!(w16 ? busy16 : busy8)) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            r++;
            ok = (w16 ? done16 : done8);
        end
        if (ok && (w16 ? busy16 : busy8)) busy_bad = 1'b1;
        res = w16 ? out16 : {8'h00, out8};
        checkOutput("done_seen", 32'(ok), 32'd1);
    endtask

    // exp_r < 0 means only the 1..2*WIDTH+1 latency bound is checked
    task automatic runCase(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                           input logic [15:0] exp_res, input int exp_r);
        int          r;
        int          bound;
        logic [15:0] res;
        bit          busy_bad;
        bound = w16 ? 33 : 17;
        applyStimulus(w16, av, bv);
        waitDone(w16, r, res, busy_bad);
        checkOutput("result", 32'(res), 32'(exp_res));
        checkOutput("busy_profile", 32'(busy_bad), 32'd0);
        if (exp_r >= 0)
            checkOutput("latency", 32'(r), 32'(exp_r));
        else
            checkOutput("latency_bound", 32'((r >= 1) && (r <= bound)), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("done_width", 32'(w16 ? done16 : done8), 32'd0);
        checkOutput("out_hold", 32'(w16 ? out16 : {8'h00, out8}), 32'(exp_res));
    endtask

    initial begin
        int          r;
        int          pulses;
        logic [15:0] res;
        bit          busy_bad;
        logic [15:0] ra, rb;

        rst = 1'b1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out", 32'(out8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            checkOutput("idle_out", 32'(out8), 32'd0);
            checkOutput("idle_done", 32'(done8), 32'd0);
            checkOutput("idle_busy", 32'(busy8), 32'd0);
        end

        // zero operands finish in the accepting edge
        runCase(1'b0, 16'd0, 16'd0, 16'd0, 0);
        runCase(1'b0, 16'd0, 16'd9, 16'd9, 0);
        runCase(1'b0, 16'd12, 16'd0, 16'd12, 0);

        runCase(1'b0, 16'd1, 16'd1, 16'd1, 1);
        runCase(1'b0, 16'd4, 16'd2, 16'd2, 3);
        runCase(1'b0, 16'd5, 16'd3, 16'd1, 3);
        runCase(1'b0, 16'd255, 16'd3, 16'd3, 7);
        runCase(1'b0, 16'd7, 16'd1, 16'd1, -1);

        // start pulsed while busy must be ignored
        applyStimulus(1'b0, 16'd48, 16'd18);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd6; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        waitDone(1'b0, r, res, busy_bad);
        checkOutput("busy_ignore_result", 32'(res), 32'd6);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        checkOutput("busy_ignore_no_second_done", 32'(pulses), 32'd0);

        // start raised in the done cycle is accepted immediately
        applyStimulus(1'b0, 16'd48, 16'd18);
        waitDone(1'b0, r, res, busy_bad);
        checkOutput("b2b_first", 32'(res), 32'd6);
        a8 = 8'd9; b8 = 8'd6; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        checkOutput("b2b_done_low", 32'(done8), 32'd0);
        checkOutput("b2b_busy", 32'(busy8), 32'd1);
        waitDone(1'b0, r, res, busy_bad);
        checkOutput("b2b_second", 32'(res), 32'd3);

        // reset in the middle of a computation aborts it
        applyStimulus(1'b0, 16'd255, 16'd3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_out", 32'(out8), 32'd0);
        checkOutput("abort_busy", 32'(busy8), 32'd0);
        checkOutput("abort_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) pulses++;
        end
        checkOutput("abort_quiet", 32'(pulses), 32'd0);
        checkOutput("abort_out_after", 32'(out8), 32'd0);
        runCase(1'b0, 16'd100, 16'd75, 16'd25, -1);

        runCase(1'b1, 16'd65535, 16'd65535, 16'd65535, 1);
        runCase(1'b1, 16'd40960, 16'd1024, 16'd1024, -1);
        runCase(1'b1, 16'd65521, 16'd65519, 16'd1, -1);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            if (i % 97 == 0) ra = 16'd0;
            if (i % 89 == 0) rb = 16'd0;
            if (ra == 16'd0 || rb == 16'd0)
                runCase(1'b1, ra, rb, ref_gcd(ra, rb), 0);
            else
                runCase(1'b1, ra, rb, ref_gcd(ra, rb), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
